// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/interrupt controller.
// FSM state encoding, ecall cause code and mtvec mode field value.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_ACTIVE,
    ST_RETURN
  } trap_state_e;

  localparam int          CAUSE_ECALL       = 11;
  localparam logic [1:0]  MTVEC_MODE_VEC    = 2'b01;
  localparam int          IRQ_CODE_BASE_DEF = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set encoder: lowest set request index wins.
// Produces a valid flag and the winning index.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan downward so the lowest set index is the last to write idx_o
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_trap_controller.sv
// Trap/interrupt controller: edge-latched IRQs, ecall, fixed priority,
// mcause/mepc capture, vectored mtvec and a four-state entry/return FSM.
module irq_trap_controller
  import trap_pkg::*;
#(
  parameter int NUM_IRQ       = 4,
  parameter int XLEN          = 32,
  parameter int IRQ_CODE_BASE = IRQ_CODE_BASE_DEF
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               global_ie,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic               mem_hold,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    mtvec,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    trap_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               trap_drop
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e        state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, pend_clr;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    tvec_q, tvec_d;

  logic               irq_vld;
  logic [IW-1:0]      irq_idx;
  logic [XLEN-1:0]    code;
  logic [XLEN-1:0]    base;

  irq_prio_enc #(
    .N  (NUM_IRQ),
    .IW (IW)
  ) u_prio (
    .req_i   (pend_q & irq_en & {NUM_IRQ{global_ie}}),
    .valid_o (irq_vld),
    .idx_o   (irq_idx)
  );

  assign code = XLEN'(IRQ_CODE_BASE) + XLEN'(irq_idx);
  assign base = {mtvec[XLEN-1:2], 2'b00};

  // Next-state, cause/vector capture and one-cycle pulses
  always_comb begin
    state_d          = state_q;
    mcause_d         = mcause_q;
    mepc_d           = mepc_q;
    tvec_d           = tvec_q;
    pend_clr         = '0;
    trigger_trap     = 1'b0;
    trigger_trap_ret = 1'b0;
    trap_drop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!mem_hold && (ecall || irq_vld)) begin
          state_d = ST_ENTER;
          mepc_d  = pc_in;
          if (ecall) begin
            mcause_d = XLEN'(CAUSE_ECALL);
            tvec_d   = base;
          end else begin
            mcause_d = {1'b1, code[XLEN-2:0]};
            tvec_d   = (mtvec[1:0] == MTVEC_MODE_VEC)
                     ? base + (code << 2) : base;
            pend_clr = NUM_IRQ'(1) << irq_idx;
          end
        end
      end
      ST_ENTER: begin
        if (!mem_hold) begin
          trigger_trap = 1'b1;
          state_d      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        trap_drop = ecall;
        if (trap_ret) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        if (!mem_hold) begin
          trigger_trap_ret = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new rising edge beats a same-cycle clear of the taken channel
  assign pend_d = (pend_q & ~pend_clr) | (irq & ~irq_q);

  // State and capture registers
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      irq_q    <= '0;
      pend_q   <= '0;
      mcause_q <= '0;
      mepc_q   <= '0;
      tvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq;
      pend_q   <= pend_d;
      mcause_q <= mcause_d;
      mepc_q   <= mepc_d;
      tvec_q   <= tvec_d;
    end
  end

  assign trapping    = (state_q == ST_ENTER) || (state_q == ST_ACTIVE);
  assign mcause      = mcause_q;
  assign mepc        = mepc_q;
  assign trap_vector = tvec_q;
  assign pending     = pend_q;

endmodule

// File: doc/irq_trap_controller.md
# irq_trap_controller

Parametrised trap/interrupt controller for the Mini-RISC-V core. It replaces the single-bit `uart_IRQ | ecall` trap logic with N edge-latched, individually masked interrupt sources plus synchronous `ecall`. It adds fixed priority, `mcause`/`mepc` generation and vectored `mtvec` support. It sits beside the CSR unit: Decode feeds it `ecall` and `trap_ret`, and it drives Fetch with `trigger_trap`, `trigger_trap_ret`, `trapping` and the trap target.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of external interrupt sources (1–16).
- `XLEN`, 32: datapath width.
- `IRQ_CODE_BASE`, 16: `mcause` code of channel 0; channel i uses `IRQ_CODE_BASE+i`.

Ports:
- `clk` in 1: system clock.
- `Rst` in 1: asynchronous, active-low reset.
- `irq` in `NUM_IRQ`: level interrupt lines, already synchronous to `clk`.
- `irq_en` in `NUM_IRQ`: per-channel enable mask (mie).
- `global_ie` in 1: global interrupt enable (mstatus.MIE).
- `ecall` in 1: one-cycle ecall pulse from Decode.
- `trap_ret` in 1: one-cycle mret pulse from Decode.
- `mem_hold` in 1: pipeline stall.
- `pc_in` in `XLEN`: PC captured into `mepc`.
- `mtvec` in `XLEN`: trap vector CSR; bits [1:0]=01 selects vectored mode.
- `trapping` out 1: a handler is active.
- `trigger_trap` out 1: one-cycle trap-entry pulse.
- `trigger_trap_ret` out 1: one-cycle return pulse.
- `mcause` out `XLEN`: cause of the current trap.
- `mepc` out `XLEN`: PC saved at trap entry.
- `trap_vector` out `XLEN`: fetch target on entry.
- `pending` out `NUM_IRQ`: latched pending bits.
- `trap_drop` out 1: one-cycle pulse when an `ecall` is ignored.

## Operation
- Edge capture: register `irq_q` and set `pending[i]` when `irq[i] & ~irq_q[i]`. A pending bit clears only when channel i is taken. If a set and a clear land in the same cycle, set wins.
- Eligible interrupts: `pending & irq_en`, gated by `global_ie`.
- Priority: `ecall` first, then the lowest-index eligible channel. `ecall` ignores both `global_ie` and `irq_en`.
- FSM states:
  - IDLE: if `!mem_hold` and a trap source exists, latch cause, `mepc <= pc_in`, clear the taken pending bit, and go to ENTER.
  - ENTER: while `mem_hold`, stay. Otherwise pulse `trigger_trap` and go to ACTIVE.
  - ACTIVE: on `trap_ret`, go to RETURN. An `ecall` here pulses `trap_drop` and is discarded. New interrupts stay pending.
  - RETURN: while `mem_hold`, stay. Otherwise pulse `trigger_trap_ret` and go to IDLE.
- `trapping` is 1 in ENTER and ACTIVE, and 0 in IDLE and RETURN.
- `trap_ret` outside ACTIVE is ignored.
- `mcause` values:
  - ecall: `XLEN'(11)`, bit `XLEN-1` = 0.
  - irq i: bit `XLEN-1` = 1, low bits = `IRQ_CODE_BASE+i`.
  - `mcause` and `mepc` hold their values until the next entry.
- `trap_vector` = `{mtvec[XLEN-1:2],2'b00}`. For interrupts in vectored mode only, add `4*code`, with the sum taken modulo 2^XLEN.

## Timing
- Reset (async, `Rst`=0): state IDLE; `pending`, `irq_q`, `mcause`, `mepc`, `trap_vector` all 0; all pulses and `trapping` 0. Reset during any state aborts with no pulse.
- Entry latency: source seen in IDLE at cycle N with no hold gives ENTER at N+1, with `trigger_trap`=1, `trapping`=1 and `mcause`/`mepc`/`trap_vector` valid. ACTIVE follows at N+2.
- IRQ latency: `irq` rising at cycle N sets `pending` at N+1; the earliest `trigger_trap` is at N+2.
- Return: `trap_ret` at cycle M in ACTIVE gives `trigger_trap_ret`=1 and `trapping`=0 at M+1. The earliest re-entry decision is at M+2, in IDLE.
- `mem_hold` stretches ENTER and RETURN; each pulse is still exactly one cycle, on the first unheld cycle.
- Back-to-back: a pending interrupt waiting through ACTIVE is taken in the first IDLE cycle after RETURN.

## Structure
- `trap_pkg`: FSM state enum (IDLE, ENTER, ACTIVE, RETURN), `CAUSE_ECALL=11`, `MTVEC_MODE_VEC=2'b01`, `IRQ_CODE_BASE` default.
- Sub-module `irq_prio_enc` (parametrised over `NUM_IRQ`): find-first-set, producing `valid` and index.
- Integration: instantiates in the core top in place of the existing trap logic. `trapping`, `trigger_trap` and `trigger_trap_ret` keep their current meaning for Fetch.

## Test plan
- Reset, then `ecall` pulse with `pc_in`=0x100 and `mtvec`=0x200 → next cycle `trigger_trap`=1, `mcause`=0x0000000B, `mepc`=0x100, `trap_vector`=0x200. `trap_ret` → next cycle `trigger_trap_ret`=1 and `trapping`=0.
- Set `mtvec`=0x201, `global_ie`=1, `irq_en`=4'b1111; raise `irq[2]` → `trigger_trap` two cycles later, `mcause`=0x80000012, `trap_vector`=0x248, `pending[2]` cleared.
- Raise `irq[3]` and `irq[1]` together → channel 1 is taken first. After `trap_ret`, channel 3 enters in the first IDLE cycle, with `mcause`=0x80000013.
- Pend `irq[0]` with `global_ie`=0 → no trap and `pending[0]`=1. Then `ecall` → the ecall is taken. Set `global_ie`=1 after the return → channel 0 is taken.
- Hold `mem_hold`=1 for 3 cycles across ENTER → `trigger_trap` is a single pulse on the first unheld cycle. `ecall` in ACTIVE → `trap_drop`=1 for one cycle and state unchanged.
- Assert `Rst`=0 mid-ACTIVE → all outputs 0 immediately. Release → IDLE with no spurious pulse.
